// File: rtl/seven_segment_scan_controller.sv
// Purpose : time-multiplexed hex seven-segment scanner with per-digit dp, blank,
//           blink, leading-zero suppression and PWM brightness; inputs are
//           double-buffered and applied only at frame boundaries.
// Ports   : clk_in/rst_in (sync, active-high); val_in/dp_in/blank_in/blink_in
//           loaded to pending on valid_in; lz_blank_in and brightness_in used live;
//           cat_out/dp_out/an_out active-low registered pins; frame_out pulses
//           the cycle digit 0 begins.
module seven_segment_scan_controller #(
   parameter int NUM_DIGITS   = 8,
   parameter int COUNT_PERIOD = 100000,
   parameter int BRIGHT_WIDTH = 4,
   parameter int BLINK_FRAMES = 64
) (
   input  logic                      clk_in,
   input  logic                      rst_in,
   input  logic [4*NUM_DIGITS-1:0]   val_in,
   input  logic [NUM_DIGITS-1:0]     dp_in,
   input  logic [NUM_DIGITS-1:0]     blank_in,
   input  logic [NUM_DIGITS-1:0]     blink_in,
   input  logic                      lz_blank_in,
   input  logic                      valid_in,
   input  logic [BRIGHT_WIDTH-1:0]   brightness_in,
   output logic [6:0]                cat_out,
   output logic                      dp_out,
   output logic [NUM_DIGITS-1:0]     an_out,
   output logic                      frame_out
);

   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [IW-1:0]           LAST_IDX   = IW'(NUM_DIGITS - 1);
   localparam logic [IW-1:0]           IDX_ONE    = IW'(1);
   localparam logic [BW-1:0]           LAST_BLINK = BW'(BLINK_FRAMES - 1);
   localparam logic [BW-1:0]           BLINK_ONE  = BW'(1);
   localparam logic [BRIGHT_WIDTH-1:0] PWM_ONE    = BRIGHT_WIDTH'(1);
   localparam logic [31:0]             SLOT_END   = 32'(COUNT_PERIOD);

   // Standard hex font, segments a..g on bits 0..6, returned active-low.
   function automatic logic [6:0] hex_to_cat(input logic [3:0] h);
      logic [6:0] seg;
      case (h)
         4'h0: seg = 7'h3F;
         4'h1: seg = 7'h06;
         4'h2: seg = 7'h5B;
         4'h3: seg = 7'h4F;
         4'h4: seg = 7'h66;
         4'h5: seg = 7'h6D;
         4'h6: seg = 7'h7D;
         4'h7: seg = 7'h07;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h6F;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h7C;
         4'hC: seg = 7'h39;
         4'hD: seg = 7'h5E;
         4'hE: seg = 7'h79;
         default: seg = 7'h71;
      endcase
      return ~seg;
   endfunction

   logic [31:0]               slot_cnt;
   logic [IW-1:0]             idx;
   logic [BRIGHT_WIDTH-1:0]   pwm_cnt;
   logic [BW-1:0]             blink_cnt;
   logic                      blink_phase;

   logic [4*NUM_DIGITS-1:0]   pend_val,   act_val;
   logic [NUM_DIGITS-1:0]     pend_dp,    act_dp;
   logic [NUM_DIGITS-1:0]     pend_blank, act_blank;
   logic [NUM_DIGITS-1:0]     pend_blink, act_blink;

   logic                      slot_end;
   logic                      boundary;
   logic                      pwm_on;
   logic                      visible;
   logic                      zero_run;
   logic [NUM_DIGITS-1:0]     lz_sup;
   logic [NUM_DIGITS-1:0]     sel;
   logic [3:0]                cur_nib;
   logic                      cur_dp, cur_blank, cur_blink, cur_lz;
   logic [NUM_DIGITS-1:0]     an_nxt;
   logic [6:0]                cat_nxt;
   logic                      dp_nxt;

   assign slot_end = (slot_cnt == SLOT_END);
   assign boundary = slot_end && (idx == LAST_IDX);
   // All-ones brightness must be fully on; the plain compare alone would
   // leave one dark cycle per PWM period.
   assign pwm_on   = (pwm_cnt < brightness_in) || (&brightness_in);

   always_comb begin
      zero_run  = lz_blank_in;
      lz_sup    = '0;
      sel       = '0;
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cur_blink = 1'b0;
      cur_lz    = 1'b0;
      // Walk from the most significant digit down: a digit is a leading zero
      // while every nibble from the top down to it is zero. Digit 0 always shows.
      for (int d = NUM_DIGITS - 1; d >= 0; d--) begin
         zero_run  = zero_run && (act_val[4*d +: 4] == 4'h0);
         lz_sup[d] = zero_run && (d != 0);
      end
      for (int d = 0; d < NUM_DIGITS; d++) begin
         if (idx == IW'(d)) begin
            sel[d]    = 1'b1;
            cur_nib   = act_val[4*d +: 4];
            cur_dp    = act_dp[d];
            cur_blank = act_blank[d];
            cur_blink = act_blink[d];
            cur_lz    = lz_sup[d];
         end
      end
      visible = !cur_blank && !cur_lz && !(cur_blink && blink_phase) && pwm_on;
      an_nxt  = '1;
      cat_nxt = '1;
      dp_nxt  = 1'b1;
      if (visible) begin
         an_nxt  = ~sel;
         cat_nxt = hex_to_cat(cur_nib);
         dp_nxt  = ~cur_dp;
      end
   end

   always_ff @(posedge clk_in) begin
      if (rst_in) begin
         slot_cnt    <= '0;
         idx         <= '0;
         pwm_cnt     <= '0;
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
         pend_val    <= '0;
         pend_dp     <= '0;
         pend_blank  <= '0;
         pend_blink  <= '0;
         act_val     <= '0;
         act_dp      <= '0;
         act_blank   <= '0;
         act_blink   <= '0;
         an_out      <= '1;
         cat_out     <= '1;
         dp_out      <= 1'b1;
         frame_out   <= 1'b0;
      end else begin
         pwm_cnt   <= pwm_cnt + PWM_ONE;
         frame_out <= boundary;

         if (valid_in) begin
            pend_val   <= val_in;
            pend_dp    <= dp_in;
            pend_blank <= blank_in;
            pend_blink <= blink_in;
         end

         if (slot_end) begin
            slot_cnt <= '0;
            idx      <= boundary ? '0 : idx + IDX_ONE;
         end else begin
            slot_cnt <= slot_cnt + 32'd1;
         end

         // Active takes the pre-edge pending value, so a load on the boundary
         // cycle itself waits for the following frame.
         if (boundary) begin
            act_val   <= pend_val;
            act_dp    <= pend_dp;
            act_blank <= pend_blank;
            act_blink <= pend_blink;
            if (blink_cnt == LAST_BLINK) begin
               blink_cnt   <= '0;
               blink_phase <= ~blink_phase;
            end else begin
               blink_cnt <= blink_cnt + BLINK_ONE;
            end
         end

         an_out  <= an_nxt;
         cat_out <= cat_nxt;
         dp_out  <= dp_nxt;
      end
   end

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
module tb_seven_segment_scan_controller;

   localparam int ND  = 4;
   localparam int CP  = 3;
   localparam int BRW = 4;
   localparam int BF  = 2;

   logic             clk_in = 1'b0;
   logic             rst_in = 1'b1;
   logic [4*ND-1:0]  val_in = '0;
   logic [ND-1:0]    dp_in = '0;
   logic [ND-1:0]    blank_in = '0;
   logic [ND-1:0]    blink_in = '0;
   logic             lz_blank_in = 1'b0;
   logic             valid_in = 1'b0;
   logic [BRW-1:0]   brightness_in = '1;
   logic [6:0]       cat_out;
   logic             dp_out;
   logic [ND-1:0]    an_out;
   logic             frame_out;

   always #5 clk_in = ~clk_in;

   seven_segment_scan_controller #(
      .NUM_DIGITS(ND), .COUNT_PERIOD(CP), .BRIGHT_WIDTH(BRW), .BLINK_FRAMES(BF)
   ) dut (
      .clk_in(clk_in), .rst_in(rst_in), .val_in(val_in), .dp_in(dp_in),
      .blank_in(blank_in), .blink_in(blink_in), .lz_blank_in(lz_blank_in),
      .valid_in(valid_in), .brightness_in(brightness_in), .cat_out(cat_out),
      .dp_out(dp_out), .an_out(an_out), .frame_out(frame_out)
   );

   typedef struct {
      logic [15:0] val;
      logic [3:0]  dp;
      logic [3:0]  blank;
      logic [3:0]  blink;
      logic        lz;
      int          digit;
      logic [3:0]  an;
      logic [6:0]  cat;
      logic        dpo;
   } vec_t;

   localparam int NV = 22;
   vec_t       vecs [NV];
   logic [6:0] cat_tab [16];

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
   endtask

   // Advance to the falling edge after posedge number k (k > cyc).
   task automatic goto(input int k);
      repeat (k - cyc) @(posedge clk_in);
      @(negedge clk_in);
      cyc = k;
   endtask

   // Reset, then present one load on the first post-reset edge (edge 0).
   task automatic restart(input logic [15:0] v, input logic [3:0] dp, input logic [3:0] bl,
                          input logic [3:0] bk, input logic lz, input logic [3:0] br);
      @(negedge clk_in);
      rst_in   = 1'b1;
      valid_in = 1'b0;
      repeat (2) @(posedge clk_in);
      @(negedge clk_in);
      rst_in        = 1'b0;
      val_in        = v;
      dp_in         = dp;
      blank_in      = bl;
      blink_in      = bk;
      lz_blank_in   = lz;
      brightness_in = br;
      valid_in      = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      cyc      = 0;
   endtask

   function automatic logic [3:0] an_for(input int d);
      logic [3:0] one;
      one = 4'b0001;
      return ~(one << d);
   endfunction

   function automatic logic [3:0] nib(input logic [15:0] v, input int d);
      return v[4*d +: 4];
   endfunction

   initial begin
      int lows;
      int d;

      cat_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

      //           val       dp     blank  blink  lz  dig  an       cat    dp
      vecs[0]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h19, 1'b1};
      vecs[1]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h30, 1'b1};
      vecs[2]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h24, 1'b1};
      vecs[3]  = '{16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h79, 1'b1};
      vecs[4]  = '{16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 3, 4'b1111, 7'h7F, 1'b1};
      vecs[5]  = '{16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 2, 4'b1111, 7'h7F, 1'b1};
      vecs[6]  = '{16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'h12, 1'b1};
      vecs[7]  = '{16'h0050, 4'h0, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
      vecs[8]  = '{16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 0, 4'b1110, 7'h40, 1'b1};
      vecs[9]  = '{16'h0000, 4'h0, 4'h0, 4'h0, 1'b1, 1, 4'b1111, 7'h7F, 1'b1};
      vecs[10] = '{16'h0000, 4'h0, 4'h0, 4'h0, 1'b0, 2, 4'b1011, 7'h40, 1'b1};
      vecs[11] = '{16'hABCD, 4'h1, 4'h0, 4'h0, 1'b0, 0, 4'b1110, 7'h21, 1'b0};
      vecs[12] = '{16'hABCD, 4'h1, 4'h0, 4'h0, 1'b0, 1, 4'b1101, 7'h46, 1'b1};
      vecs[13] = '{16'hABCD, 4'h1, 4'h0, 4'h0, 1'b0, 3, 4'b0111, 7'h08, 1'b1};
      vecs[14] = '{16'h89EF, 4'h0, 4'h4, 4'h0, 1'b0, 2, 4'b1111, 7'h7F, 1'b1};
      vecs[15] = '{16'h89EF, 4'h0, 4'h4, 4'h0, 1'b0, 3, 4'b0111, 7'h00, 1'b1};
      vecs[16] = '{16'h89EF, 4'h0, 4'h4, 4'h0, 1'b0, 1, 4'b1101, 7'h06, 1'b1};
      vecs[17] = '{16'h89EF, 4'h0, 4'h4, 4'h0, 1'b0, 0, 4'b1110, 7'h0E, 1'b1};
      vecs[18] = '{16'h6707, 4'hF, 4'h0, 4'h0, 1'b1, 1, 4'b1101, 7'h40, 1'b0};
      vecs[19] = '{16'h6707, 4'hF, 4'h0, 4'h0, 1'b1, 2, 4'b1011, 7'h78, 1'b0};
      vecs[20] = '{16'hF000, 4'h0, 4'h0, 4'h0, 1'b1, 3, 4'b0111, 7'h0E, 1'b1};
      vecs[21] = '{16'hF000, 4'h0, 4'h0, 4'h0, 1'b1, 2, 4'b1011, 7'h40, 1'b1};

      // Reset state
      repeat (3) @(posedge clk_in);
      @(negedge clk_in);
      check("reset an_out",    32'(an_out),    32'hF);
      check("reset cat_out",   32'(cat_out),   32'h7F);
      check("reset dp_out",    32'(dp_out),    32'h1);
      check("reset frame_out", 32'(frame_out), 32'h0);

      // Table: middle of each digit's slot in the first frame after the load
      for (int i = 0; i < NV; i++) begin
         restart(vecs[i].val, vecs[i].dp, vecs[i].blank, vecs[i].blink, vecs[i].lz, 4'hF);
         goto(16 + 4*vecs[i].digit + 1);
         check($sformatf("vec%0d an_out", i),  32'(an_out),  32'(vecs[i].an));
         check($sformatf("vec%0d cat_out", i), 32'(cat_out), 32'(vecs[i].cat));
         check($sformatf("vec%0d dp_out", i),  32'(dp_out),  32'(vecs[i].dpo));
      end

      // Scan order, frame pulse timing, zero contents until the first boundary
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
      for (int k = 0; k < 48; k++) begin
         if (k > 0) goto(k);
         d = (k / 4) % 4;
         check("scan frame_out", 32'(frame_out), 32'((k % 16) == 15));
         check("scan an_out",    32'(an_out),    32'(an_for(d)));
         check("scan cat_out",   32'(cat_out),
               32'((k < 16) ? cat_tab[0] : cat_tab[nib(16'h1234, d)]));
      end

      // Mid-frame loads: last one before the boundary wins; boundary load waits a frame
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
      goto(20); val_in = 16'hABCD; valid_in = 1'b1;
      goto(21); valid_in = 1'b0;
      goto(22); val_in = 16'h5555; valid_in = 1'b1;
      goto(23); valid_in = 1'b0;
      goto(24); check("midload digit2 old", 32'(cat_out), 32'h24);
      goto(28); check("midload digit3 old", 32'(cat_out), 32'h79);
      goto(32); check("midload digit0 new", 32'(cat_out), 32'h12);
                check("midload digit0 an",  32'(an_out),  32'hE);
      goto(36); check("midload digit1 new", 32'(cat_out), 32'h12);
      goto(46); val_in = 16'h9999; valid_in = 1'b1;
      goto(47); valid_in = 1'b0;
                check("boundary frame_out", 32'(frame_out), 32'h1);
      goto(48); check("boundary load deferred", 32'(cat_out), 32'h12);
      goto(64); check("boundary load applied",  32'(cat_out), 32'h10);

      // PWM brightness 4 of 16
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd4);
      lows = 0;
      for (int k = 16; k < 48; k++) begin
         goto(k);
         d = (k / 4) % 4;
         if (an_out != 4'hF) lows++;
         check("pwm4 an_out", 32'(an_out), 32'(((k % 16) < 4) ? an_for(d) : 4'hF));
      end
      check("pwm4 lit count", 32'(lows), 32'd8);

      // PWM brightness 0: dark
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'd0);
      lows = 0;
      for (int k = 16; k < 48; k++) begin
         goto(k);
         if (an_out != 4'hF) lows++;
      end
      check("pwm0 lit count", 32'(lows), 32'd0);

      // Blink digit 1 with two frames per half period; dp on digit 0
      restart(16'h1234, 4'h1, 4'h0, 4'h2, 1'b0, 4'hF);
      for (int f = 1; f < 8; f++) begin
         goto(16*f + 1);
         check("blink digit0 an", 32'(an_out), 32'hE);
         check("blink digit0 dp", 32'(dp_out), 32'h0);
         goto(16*f + 5);
         check("blink digit1 an", 32'(an_out), 32'(((f / 2) % 2 == 1) ? 4'hF : 4'hD));
      end

      // Reset in the middle of digit 2's slot
      restart(16'h1234, 4'h0, 4'h0, 4'h0, 1'b0, 4'hF);
      goto(26);
      check("pre-reset an_out", 32'(an_out), 32'hB);
      rst_in = 1'b1;
      goto(27);
      check("midreset an_out",  32'(an_out),  32'hF);
      check("midreset cat_out", 32'(cat_out), 32'h7F);
      check("midreset dp_out",  32'(dp_out),  32'h1);
      rst_in = 1'b0;
      cyc = -1;
      goto(0);
      check("restart an_out",  32'(an_out),  32'hE);
      check("restart cat_out", 32'(cat_out), 32'h40);
      for (int k = 1; k <= 17; k++) begin
         goto(k);
         check("restart frame_out", 32'(frame_out), 32'(k == 15));
      end
      check("restart zeros an",  32'(an_out),  32'hE);
      check("restart zeros cat", 32'(cat_out), 32'h40);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
